// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the main-memory responder: refresh state,
// default sizing and the address-to-array-index wrap.
package mem_resp_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    REFRESH = 1'b1
  } mem_state_t;

  localparam int unsigned DEFAULT_READ_LATENCY = 32'd4;
  localparam int unsigned DEFAULT_QUEUE_DEPTH  = 32'd4;

  // Keep only the low depth_log2 bits; callers truncate to the index width.
  function automatic logic [63:0] idx_of(input logic [63:0] addr, input int unsigned depth_log2);
    return addr & ((64'd1 << depth_log2) - 64'd1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers/count and a combinational head.
// A push while full is ignored even if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == (PTR_W+1)'(DEPTH));
  assign empty  = (count_r == {(PTR_W+1){1'b0}});
  assign count  = count_r;
  assign dout   = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// Word-addressed memory model: posted writes, queued in-order reads with fixed
// latency, and periodic refresh blackouts that pause read issue.
module main_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int    ADDR_WIDTH     = 32,
  parameter int    WORD_WIDTH     = 32,
  parameter int    DEPTH_LOG2     = 12,
  parameter int    READ_LATENCY   = DEFAULT_READ_LATENCY,
  parameter int    QUEUE_DEPTH    = DEFAULT_QUEUE_DEPTH,
  parameter int    REFRESH_PERIOD = 64,
  parameter int    REFRESH_CYCLES = 8,
  parameter string INIT_FILE      = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] memory_addr,
  input  logic                  memory_write_en,
  input  logic [WORD_WIDTH-1:0] memory_write_data,
  input  logic                  memory_read_addr_valid,
  output logic                  memory_read_ready,
  output logic                  memory_read_valid,
  output logic [WORD_WIDTH-1:0] memory_read_data
);

  localparam int          STAGES        = READ_LATENCY - 1;
  localparam int          CNT_W         = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [31:0] PERIOD_LAST   = (REFRESH_PERIOD > 0) ? 32'(REFRESH_PERIOD - 1) : 32'd0;
  localparam logic [31:0] BLACKOUT_LAST = 32'(REFRESH_CYCLES - 1);

  logic [WORD_WIDTH-1:0] mem_r [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] addr_idx_s;
  logic [DEPTH_LOG2-1:0] head_idx_s;
  logic [CNT_W-1:0]      q_count_s;
  logic                  q_empty_s;
  logic                  unused_q_full_s;
  logic                  push_s;
  logic                  issue_s;
  logic [WORD_WIDTH-1:0] issue_data_s;
  mem_state_t            state_r;
  logic [31:0]           refresh_cnt_r;
  logic [STAGES-1:0]     pipe_valid_r;
  logic [WORD_WIDTH-1:0] pipe_data_r [STAGES];

  assign addr_idx_s        = DEPTH_LOG2'(idx_of(64'(memory_addr), DEPTH_LOG2));
  assign memory_read_ready = (q_count_s < CNT_W'(QUEUE_DEPTH));
  assign push_s            = memory_read_addr_valid && memory_read_ready;
  assign issue_s           = (state_r == RUN) && !q_empty_s;

  // The queue stores array indices, so the wrap is applied once at acceptance.
  sync_fifo #(
    .WIDTH (DEPTH_LOG2),
    .DEPTH (QUEUE_DEPTH)
  ) u_req_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (issue_s),
    .din   (addr_idx_s),
    .dout  (head_idx_s),
    .full  (unused_q_full_s),
    .empty (q_empty_s),
    .count (q_count_s)
  );

  // Write-first forwarding so a same-edge write is seen by the issuing read.
  always_comb begin
    issue_data_s = mem_r[head_idx_s];
    if (memory_write_en && (addr_idx_s == head_idx_s)) begin
      issue_data_s = memory_write_data;
    end else begin
      issue_data_s = mem_r[head_idx_s];
    end
  end

  // Posted writes; the array survives reset.
  always_ff @(posedge clk) begin
    if (memory_write_en) begin
      mem_r[addr_idx_s] <= memory_write_data;
    end
  end

  // Refresh FSM; one counter times both the RUN window and the blackout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      refresh_cnt_r <= 32'd0;
    end else if (REFRESH_PERIOD == 0) begin
      state_r       <= RUN;
      refresh_cnt_r <= 32'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (refresh_cnt_r == PERIOD_LAST) begin
            refresh_cnt_r <= 32'd0;
            state_r       <= REFRESH;
          end else begin
            refresh_cnt_r <= refresh_cnt_r + 32'd1;
          end
        end
        REFRESH: begin
          if (refresh_cnt_r == BLACKOUT_LAST) begin
            refresh_cnt_r <= 32'd0;
            state_r       <= RUN;
          end else begin
            refresh_cnt_r <= refresh_cnt_r + 32'd1;
          end
        end
        default: begin
          state_r       <= RUN;
          refresh_cnt_r <= 32'd0;
        end
      endcase
    end
  end

  // Read pipeline plus output register; data holds while no response is due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid_r      <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        pipe_data_r[i] <= {WORD_WIDTH{1'b0}};
      end
      memory_read_valid <= 1'b0;
      memory_read_data  <= {WORD_WIDTH{1'b0}};
    end else begin
      pipe_valid_r[0] <= issue_s;
      pipe_data_r[0]  <= issue_data_s;
      for (int i = 1; i < STAGES; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_data_r[i]  <= pipe_data_r[i-1];
      end
      memory_read_valid <= pipe_valid_r[STAGES-1];
      if (pipe_valid_r[STAGES-1]) begin
        memory_read_data <= pipe_data_r[STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Scoreboard bench: dut0 runs without refresh, dut1 with a 32/8 refresh cycle.
module tb_main_memory_responder;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic [31:0] addr0, wd0, addr1, wd1;
  logic        we0, rv0, we1, rv1;
  logic        ready0, valid0, ready1, valid1;
  logic [31:0] data0, data1;

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          resp0_cyc[$];
  int          resp1_cyc[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  main_memory_responder #(.REFRESH_PERIOD(0)) dut0 (
    .clk(clk), .rst(rst0), .memory_addr(addr0), .memory_write_en(we0),
    .memory_write_data(wd0), .memory_read_addr_valid(rv0),
    .memory_read_ready(ready0), .memory_read_valid(valid0), .memory_read_data(data0)
  );

  main_memory_responder #(.REFRESH_PERIOD(32), .REFRESH_CYCLES(8)) dut1 (
    .clk(clk), .rst(rst1), .memory_addr(addr1), .memory_write_en(we1),
    .memory_write_data(wd1), .memory_read_addr_valid(rv1),
    .memory_read_ready(ready1), .memory_read_valid(valid1), .memory_read_data(data1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dut0 response monitor
  always @(negedge clk) begin
    if (!rst0 && valid0 === 1'b1) begin
      if (exp0.size() == 0) begin
        checks++;
        $display("FAIL dut0_unexpected_resp: got %h, expected no response", data0);
      end else begin
        check("dut0_data", data0, exp0.pop_front());
        resp0_cyc.push_back(cyc);
      end
    end
  end

  // dut1 response monitor
  always @(negedge clk) begin
    if (!rst1 && valid1 === 1'b1) begin
      if (exp1.size() == 0) begin
        checks++;
        $display("FAIL dut1_unexpected_resp: got %h, expected no response", data1);
      end else begin
        check("dut1_data", data1, exp1.pop_front());
        resp1_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  pat;
    logic [31:0] sent;
    logic        acc, saw_nr, hit;
    int          nr, ngaps, maxgap;

    rst0 = 1'b1; rst1 = 1'b1;
    addr0 = 32'd0; wd0 = 32'd0; we0 = 1'b0; rv0 = 1'b0;
    addr1 = 32'd0; wd1 = 32'd0; we1 = 1'b0; rv1 = 1'b0;
    repeat (3) tick();
    check("rst_ready", {31'd0, ready0}, 32'd1);
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_data", data0, 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;

    // preload word i = i at 0x40..0x4F in both instances
    for (int i = 0; i < 16; i++) begin
      addr0 = 32'h40 + 32'(i); wd0 = 32'h40 + 32'(i); we0 = 1'b1;
      addr1 = 32'h40 + 32'(i); wd1 = 32'h40 + 32'(i); we1 = 1'b1;
      tick();
    end
    we0 = 1'b0; we1 = 1'b0;

    // write then read with latency profile
    addr0 = 32'h10; wd0 = 32'hDEADBEEF; we0 = 1'b1; tick(); we0 = 1'b0;
    rv0 = 1'b1; exp0.push_back(32'hDEADBEEF); tick(); rv0 = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      pat[j] = valid0;
    end
    check("latency_profile", {26'd0, pat}, 32'h10);
    tick();

    // fill burst, refresh disabled
    resp0_cyc.delete();
    nr = 0;
    for (int i = 0; i < 16; i++) begin
      addr0 = 32'h40 + 32'(i); rv0 = 1'b1;
      if (!ready0) nr++;
      exp0.push_back(32'h40 + 32'(i));
      tick();
    end
    rv0 = 1'b0;
    for (int t = 0; t < 40 && resp0_cyc.size() < 16; t++) tick();
    check("fill_ready_drops", 32'(nr), 32'd0);
    check("fill_count", 32'(resp0_cyc.size()), 32'd16);
    if (resp0_cyc.size() == 16) check("fill_span", 32'(resp0_cyc[15] - resp0_cyc[0]), 32'd15);

    // forwarding: write lands on the edge the queued read issues
    addr0 = 32'd3; wd0 = 32'h11; we0 = 1'b1; tick(); we0 = 1'b0;
    rv0 = 1'b1; tick(); rv0 = 1'b0;
    addr0 = 32'd3; wd0 = 32'h5A5A5A5A; we0 = 1'b1; exp0.push_back(32'h5A5A5A5A);
    tick(); we0 = 1'b0;
    repeat (6) tick();

    // wrap: 0x1003 aliases index 3
    addr0 = 32'h1003; wd0 = 32'h77; we0 = 1'b1; tick(); we0 = 1'b0;
    addr0 = 32'd3; rv0 = 1'b1; exp0.push_back(32'h77); tick(); rv0 = 1'b0;
    repeat (6) tick();
    check("dut0_drained", 32'(exp0.size()), 32'd0);

    // reset after 5 of 16 burst responses
    resp0_cyc.delete();
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr0 = 32'h40 + 32'(i); rv0 = 1'b1; acc = ready0;
      @(posedge clk);
      if (acc) exp0.push_back(32'h40 + 32'(i));
      #1;
      if (resp0_cyc.size() >= 5) begin
        rst0 = 1'b1; rv0 = 1'b0; exp0.delete(); hit = 1'b1;
        break;
      end
    end
    rv0 = 1'b0;
    #1;
    check("midrst_hit", {31'd0, hit}, 32'd1);
    check("midrst_resp_before", 32'(resp0_cyc.size()), 32'd5);
    check("midrst_valid", {31'd0, valid0}, 32'd0);
    check("midrst_ready", {31'd0, ready0}, 32'd1);
    tick(); tick(); rst0 = 1'b0;
    repeat (10) tick();
    check("midrst_no_more", 32'(resp0_cyc.size()), 32'd5);
    addr0 = 32'h42; rv0 = 1'b1; exp0.push_back(32'h42); tick(); rv0 = 1'b0;
    repeat (6) tick();
    check("midrst_read42", 32'(resp0_cyc.size()), 32'd6);

    // refresh stall on dut1: realign its refresh counter, then straddle a blackout
    rst1 = 1'b1; tick(); tick(); rst1 = 1'b0;
    repeat (23) tick();
    resp1_cyc.delete();
    sent = 32'd0; saw_nr = 1'b0;
    for (int t = 0; t < 80 && sent < 32'd16; t++) begin
      addr1 = 32'h40 + sent; rv1 = 1'b1; acc = ready1;
      if (!ready1) saw_nr = 1'b1;
      @(posedge clk);
      if (acc) begin
        exp1.push_back(32'h40 + sent);
        sent = sent + 32'd1;
      end
      #1;
    end
    rv1 = 1'b0;
    for (int t = 0; t < 60 && resp1_cyc.size() < 16; t++) tick();
    check("refresh_ready_dropped", {31'd0, saw_nr}, 32'd1);
    check("refresh_count", 32'(resp1_cyc.size()), 32'd16);
    if (resp1_cyc.size() == 16) begin
      ngaps = 0; maxgap = 0;
      for (int j = 1; j < 16; j++) begin
        if (resp1_cyc[j] - resp1_cyc[j-1] != 1) ngaps++;
        if (resp1_cyc[j] - resp1_cyc[j-1] > maxgap) maxgap = resp1_cyc[j] - resp1_cyc[j-1];
      end
      check("refresh_gap_count", 32'(ngaps), 32'd1);
      check("refresh_gap_len", 32'(maxgap), 32'd9);
      check("refresh_span", 32'(resp1_cyc[15] - resp1_cyc[0]), 32'd23);
    end
    check("dut1_drained", 32'(exp1.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
